// File: rtl/fetch.sv
// fetch: instruction-fetch stage feeding decode.
//
// Owns the program counter and issues in-order word requests to an
// instruction memory with variable latency. Returned words are paired with
// the PC they were fetched from and buffered in a small FIFO whose head is
// presented to decode. A redirect flushes the buffer, retargets the PC and
// marks every request still in flight as stale so its response is dropped.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   F_stall             decode cannot accept; head entry is held
//   F_redirect          taken jump/branch: flush and refetch from F_redirect_pc
//   F_redirect_pc       redirect target (low two bits ignored)
//   imem_req/addr       request valid and word-aligned byte address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/rdata   in-order response valid and instruction word
//   F_valid/inst/pc     head instruction and its PC for decode (zero when empty)
module fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            F_stall,
    input  logic            F_redirect,
    input  logic [XLEN-1:0] F_redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            F_valid,
    output logic [XLEN-1:0] F_inst,
    output logic [XLEN-1:0] F_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_stale;

    // Instruction buffer: word plus the PC it came from.
    logic [XLEN-1:0] r_bufInst [DEPTH];
    logic [XLEN-1:0] r_bufPc   [DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // PCs of requests in flight, in issue order, so a response can be tagged.
    logic [XLEN-1:0] r_trkPc [DEPTH];
    logic [AW-1:0]   r_trkHead;
    logic [AW-1:0]   r_trkTail;

    logic            w_credit;
    logic            w_fire;
    logic            w_pop;
    logic            w_write;
    logic [CW-1:0]   w_outNext;
    logic [XLEN-1:0] w_target;

    // In-flight requests plus buffered words never exceed DEPTH, so every
    // response is guaranteed a free buffer slot.
    assign w_credit  = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
    assign imem_req  = !rst && !F_redirect && w_credit;
    assign imem_addr = r_pc;

    assign w_fire    = imem_req && imem_ready;
    assign w_pop     = F_valid && !F_stall;
    assign w_write   = imem_rvalid && (r_stale == '0);
    assign w_outNext = r_outstanding + CW'(w_fire) - CW'(imem_rvalid);
    assign w_target  = F_redirect_pc & ~XLEN'(3);

    assign F_valid = (r_count != '0);
    assign F_inst  = F_valid ? r_bufInst[r_head] : '0;
    assign F_pc    = F_valid ? r_bufPc[r_head]   : '0;

    // PC, request tracking, stale accounting and the instruction buffer.
    // Redirect wins over stall and over any same-cycle buffer write or pop;
    // requests still in flight after this cycle become stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_trkHead     <= '0;
            r_trkTail     <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (w_fire) begin
                r_trkPc[r_trkTail] <= r_pc;
                r_trkTail          <= r_trkTail + AW'(1);
            end
            if (imem_rvalid) begin
                r_trkHead <= r_trkHead + AW'(1);
            end

            if (F_redirect) begin
                r_pc    <= w_target;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_stale <= w_outNext;
            end else begin
                if (w_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (imem_rvalid && (r_stale != '0)) begin
                    r_stale <= r_stale - CW'(1);
                end
                if (w_write) begin
                    r_bufInst[r_tail] <= imem_rdata;
                    r_bufPc[r_tail]   <= r_trkPc[r_trkHead];
                    r_tail            <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count + CW'(w_write) - CW'(w_pop);
            end
        end
    end

    // A response into a full buffer would mean the credit rule was broken.
    assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized self-checking bench for the fetch stage.
// A queue-based model of the fetch rules (PC, in-flight request list, stale
// count, instruction buffer) predicts every output each cycle, and a
// behavioural memory returns a hash of the address for each request.
module tb_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        F_stall;
    logic        F_redirect;
    logic [31:0] F_redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        F_valid;
    logic [31:0] F_inst;
    logic [31:0] F_pc;

    fetch #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .F_stall       (F_stall),
        .F_redirect    (F_redirect),
        .F_redirect_pc (F_redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .F_valid       (F_valid),
        .F_inst        (F_inst),
        .F_pc          (F_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    req_t        inFlight[$];
    ent_t        buffer[$];
    int          staleCnt;
    logic [31:0] modelPc;
    int          cycle;
    int          testsRun;
    int          testsFailed;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] pickTarget();
        logic [31:0] t;
        case ($urandom_range(2))
            0:       t = $urandom & 32'h0000_0FFF;
            1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: t = $urandom;
        endcase
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h",
                     tag, cycle, observed, expected);
        end
    endtask

    task automatic modelReset();
        inFlight.delete();
        buffer.delete();
        staleCnt = 0;
        modelPc  = RESET_PC;
    endtask

    // One clock of stimulus: drive inputs at the falling edge, check the
    // predicted outputs, then advance the model across the rising edge.
    task automatic applyStimulus(input int stallPct, input int readyPct,
                                 input int respPct, input int redirPct,
                                 input logic [31:0] target);
        logic expReq, fire, respond, pop;
        req_t r;
        @(negedge clk);
        cycle++;
        rst           = 1'b0;
        F_stall       = ($urandom_range(99) < stallPct);
        F_redirect    = ($urandom_range(99) < redirPct);
        F_redirect_pc = target;
        imem_ready    = ($urandom_range(99) < readyPct);
        respond       = (inFlight.size() > 0) && (inFlight[0].cyc < cycle) &&
                        ($urandom_range(99) < respPct);
        imem_rvalid   = respond;
        imem_rdata    = respond ? memWord(inFlight[0].addr) : $urandom;
        #1;
        expReq = !F_redirect && ((inFlight.size() + buffer.size()) < DEPTH);
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        if (expReq) checkOutput("imem_addr", imem_addr, modelPc);
        checkOutput("F_valid", {31'b0, F_valid}, {31'b0, buffer.size() > 0});
        checkOutput("F_inst", F_inst, (buffer.size() > 0) ? buffer[0].inst : 32'h0);
        checkOutput("F_pc", F_pc, (buffer.size() > 0) ? buffer[0].pc : 32'h0);

        fire = expReq && imem_ready;
        pop  = (buffer.size() > 0) && !F_stall;
        if (pop) void'(buffer.pop_front());
        if (respond) begin
            r = inFlight.pop_front();
            if (staleCnt > 0) staleCnt--;
            else buffer.push_back('{inst: memWord(r.addr), pc: r.addr});
        end
        if (fire) begin
            inFlight.push_back('{addr: modelPc, cyc: cycle});
            modelPc = modelPc + 32'd4;
        end
        if (F_redirect) begin
            buffer.delete();
            staleCnt = inFlight.size();
            modelPc  = target & ~32'h3;
        end
    endtask

    // Reset cycle: no responses are returned and no request may be raised.
    task automatic resetCycle();
        @(negedge clk);
        cycle++;
        rst         = 1'b1;
        F_stall     = 1'b0;
        F_redirect  = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        checkOutput("imem_req_in_reset", {31'b0, imem_req}, 32'h0);
        modelReset();
    endtask

    // Directed scenarios from the fetch behaviour, then a long random mix
    // with occasional mid-stream resets.
    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        cycle         = 0;
        rst           = 1'b1;
        F_stall       = 1'b0;
        F_redirect    = 1'b0;
        F_redirect_pc = 32'h0;
        imem_ready    = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        modelReset();
        resetCycle();
        resetCycle();

        for (int i = 0; i < 12; i++) applyStimulus(0, 100, 100, 0, 32'h0);
        for (int i = 0; i < 5; i++)  applyStimulus(100, 100, 100, 0, 32'h0);
        for (int i = 0; i < 6; i++)  applyStimulus(0, 100, 100, 0, 32'h0);
        for (int i = 0; i < 3; i++)  applyStimulus(0, 0, 100, 0, 32'h0);
        for (int i = 0; i < 4; i++)  applyStimulus(0, 100, 100, 0, 32'h0);
        applyStimulus(0, 100, 0, 0, 32'h0);
        applyStimulus(0, 100, 0, 0, 32'h0);
        applyStimulus(0, 100, 0, 100, 32'h100);
        for (int i = 0; i < 8; i++)  applyStimulus(0, 100, 100, 0, 32'h0);
        for (int i = 0; i < 4; i++)  applyStimulus(100, 100, 100, 0, 32'h0);
        applyStimulus(100, 100, 100, 100, 32'h100);
        for (int i = 0; i < 6; i++)  applyStimulus(0, 100, 100, 0, 32'h0);
        applyStimulus(0, 100, 100, 100, 32'hFFFF_FFFB);
        for (int i = 0; i < 6; i++)  applyStimulus(0, 100, 100, 0, 32'h0);
        resetCycle();
        for (int i = 0; i < 6; i++)  applyStimulus(0, 100, 100, 0, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            if ((i % 700) == 699) resetCycle();
            else applyStimulus(30, 60, 50, 6, pickTarget());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
